alu_seq: RTL and testbench

- Parametrised, handshaked, multi-cycle successor to the datapath's 16-function combinational ALU. Same 4-bit function encoding.
- Shift operations shift by a variable amount taken from B and execute iteratively, one bit per cycle.
- All results are registered and carry a per-result overflow flag plus a sticky overflow status.
- Sits between operand issue logic and writeback, decoupled on both sides by valid/ready handshakes.

---
 rtl/alu_seq.sv | 159 +++++++++++++++
 tb/tb_alu_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Handshaked multi-cycle ALU: 16-function encoding, iterative one-bit-per-cycle shifts,
// registered result with per-result overflow and a sticky overflow status.
module alu_seq #(
  parameter int DATA_WIDTH  = 16,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            func_code,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow,
  output logic                  ovf_sticky,
  input  logic                  clr_ovf,
  output logic                  busy
);

  localparam int MSB = DATA_WIDTH - 1;

  localparam logic [3:0] F_ADD  = 4'b0000;
  localparam logic [3:0] F_SUB  = 4'b0001;
  localparam logic [3:0] F_PASS = 4'b0010;
  localparam logic [3:0] F_NOT  = 4'b0011;
  localparam logic [3:0] F_AND  = 4'b0100;
  localparam logic [3:0] F_OR   = 4'b0101;
  localparam logic [3:0] F_NAND = 4'b0110;
  localparam logic [3:0] F_NOR  = 4'b0111;
  localparam logic [3:0] F_XOR  = 4'b1000;
  localparam logic [3:0] F_XNOR = 4'b1001;
  localparam logic [3:0] F_LSL  = 4'b1010;
  localparam logic [3:0] F_LSR  = 4'b1011;
  localparam logic [3:0] F_ASL  = 4'b1100;
  localparam logic [3:0] F_ASR  = 4'b1101;
  localparam logic [3:0] F_NEG  = 4'b1110;
  localparam logic [3:0] F_ZERO = 4'b1111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   sum, diff, alu_result;
  logic                    alu_ovf;
  logic [DATA_WIDTH-1:0]   work_q, work_next, result_q;
  logic [SHAMT_WIDTH-1:0]  cnt_q, shamt;
  logic                    shift_right_q, shift_arith_q;
  logic                    overflow_q, sticky_q;
  logic                    accept, consume, is_shift, start_shift, shift_last;

  assign shamt       = b[SHAMT_WIDTH-1:0];
  assign is_shift    = (func_code == F_LSL) || (func_code == F_LSR) ||
                       (func_code == F_ASL) || (func_code == F_ASR);
  assign start_shift = is_shift && (shamt != '0);

  assign in_ready   = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q == SHIFT);
  assign accept     = in_valid && in_ready;
  assign consume    = out_valid && out_ready;
  assign shift_last = (state_q == SHIFT) && (cnt_q == SHAMT_WIDTH'(1));

  assign result     = result_q;
  assign overflow   = overflow_q;
  assign ovf_sticky = sticky_q;

  assign sum  = a + b;
  assign diff = a - b;

  // Right shifts fill with the old MSB only for the arithmetic variant.
  assign work_next = shift_right_q ? {shift_arith_q & work_q[MSB], work_q[MSB:1]}
                                   : {work_q[MSB-1:0], 1'b0};

  // Single-cycle functions; shift codes land here only with a zero amount, giving A.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    alu_result = '0;
    alu_ovf    = 1'b0;
    case (func_code)
      F_ADD: begin
        alu_result = sum;
        alu_ovf    = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      F_SUB: begin
        alu_result = diff;
        alu_ovf    = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      F_PASS: alu_result = a;
      F_NOT:  alu_result = ~a;
      F_AND:  alu_result = a & b;
      F_OR:   alu_result = a | b;
      F_NAND: alu_result = ~(a & b);
      F_NOR:  alu_result = ~(a | b);
      F_XOR:  alu_result = a ^ b;
      F_XNOR: alu_result = ~(a ^ b);
      F_LSL, F_LSR, F_ASL, F_ASR: alu_result = a;
      F_NEG:  alu_result = ~a + 1'b1;
      F_ZERO: alu_result = '0;
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept)       state_d = start_shift ? SHIFT : DONE;
        else if (consume) state_d = IDLE;
      end
      SHIFT:   if (shift_last) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      work_q        <= '0;
      cnt_q         <= '0;
      shift_right_q <= 1'b0;
      shift_arith_q <= 1'b0;
      result_q      <= '0;
      overflow_q    <= 1'b0;
    end else if (accept) begin
      if (start_shift) begin
        work_q        <= a;
        cnt_q         <= shamt;
        shift_right_q <= func_code[0];
        shift_arith_q <= (func_code == F_ASR);
        overflow_q    <= 1'b0;
      end else begin
        result_q   <= alu_result;
        overflow_q <= alu_ovf;
      end
    end else if (state_q == SHIFT) begin
      work_q <= work_next;
      cnt_q  <= cnt_q - SHAMT_WIDTH'(1);
      if (shift_last) begin
        result_q   <= work_next;
        overflow_q <= 1'b0;
      end
    end
  end

  // A set on the consume edge takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  sticky_q <= 1'b0;
    else if (consume && overflow_q) sticky_q <= 1'b1;
    else if (clr_ovf)              sticky_q <= 1'b0;
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: vector table through a result scoreboard, plus
// hand-written backpressure, sticky-overflow and mid-shift reset sequences.
module tb_alu_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         clr_ovf = 1'b0;
  logic [3:0]   func_code = 4'h0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, overflow, ovf_sticky, busy;
  logic [W-1:0] result;

  alu_seq #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .func_code  (func_code),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .overflow   (overflow),
    .ovf_sticky (ovf_sticky),
    .clr_ovf    (clr_ovf),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   func;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_result;
    logic         exp_ovf;
    int           exp_busy;
  } vec_t;

  typedef struct {
    logic [W-1:0] result;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Outputs are stable from the rising edge, so a consume on the next edge is decided here.
  always @(negedge clk) begin
    if (mon_en && reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got %h with no pending expectation", result);
      end else begin
        mon_e = sb.pop_front();
        check("sb_result", 32'(result), 32'(mon_e.result));
        check("sb_overflow", 32'(overflow), 32'(mon_e.ovf));
      end
    end
  end

  // Issue one request with out_ready held high; checks busy/in_ready while shifting.
  task automatic run_op(input vec_t v);
    int  busy_cycles;
    int  waited;
    bit  seen;
    @(posedge clk); #1;
    in_valid  = 1'b1;
    func_code = v.func;
    a         = v.a;
    b         = v.b;
    waited    = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check($sformatf("accept_ready_f%h", v.func), 32'(in_ready), 32'd1);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    sb.push_back('{v.exp_result, v.exp_ovf});
    @(posedge clk); #1;
    in_valid  = 1'b0;
    func_code = 4'($urandom);
    a         = W'($urandom);
    b         = W'($urandom);
    busy_cycles = 0;
    seen        = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else begin
        busy_cycles++;
        check($sformatf("shift_flags_f%h", v.func), 32'({busy, in_ready}), 32'b10);
      end
    end
    check($sformatf("out_valid_seen_f%h", v.func), 32'(seen), 32'd1);
    check($sformatf("busy_cycles_f%h", v.func), 32'(busy_cycles), 32'(v.exp_busy));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //                 func   a         b         result    ovf   busy
    vecs.push_back('{4'h1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 0});
    vecs.push_back('{4'h1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 0});
    vecs.push_back('{4'h0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 0});
    vecs.push_back('{4'h0, 16'h0003, 16'h0004, 16'h0007, 1'b0, 0});
    vecs.push_back('{4'h1, 16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 0});
    vecs.push_back('{4'h2, 16'h1234, 16'h5555, 16'h1234, 1'b0, 0});
    vecs.push_back('{4'h3, 16'h1234, 16'h0000, 16'hEDCB, 1'b0, 0});
    vecs.push_back('{4'h4, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 0});
    vecs.push_back('{4'h5, 16'hF0F0, 16'h0F00, 16'hFFF0, 1'b0, 0});
    vecs.push_back('{4'h6, 16'hF0F0, 16'hFF00, 16'h0FFF, 1'b0, 0});
    vecs.push_back('{4'h7, 16'hF0F0, 16'h0F00, 16'h000F, 1'b0, 0});
    vecs.push_back('{4'h8, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0, 0});
    vecs.push_back('{4'h9, 16'hF0F0, 16'hFF00, 16'hF00F, 1'b0, 0});
    vecs.push_back('{4'hD, 16'h8F00, 16'h0004, 16'hF8F0, 1'b0, 4});
    vecs.push_back('{4'hB, 16'h8F00, 16'h0004, 16'h08F0, 1'b0, 4});
    vecs.push_back('{4'hA, 16'h1234, 16'h0000, 16'h1234, 1'b0, 0});
    vecs.push_back('{4'hA, 16'h0001, 16'h000F, 16'h8000, 1'b0, 15});
    vecs.push_back('{4'hC, 16'hC003, 16'h0012, 16'h000C, 1'b0, 2});
    vecs.push_back('{4'hD, 16'h4000, 16'h0003, 16'h0800, 1'b0, 3});
    vecs.push_back('{4'hD, 16'h8000, 16'h000F, 16'hFFFF, 1'b0, 15});
    vecs.push_back('{4'hE, 16'h8000, 16'h0000, 16'h8000, 1'b0, 0});
    vecs.push_back('{4'hE, 16'h0001, 16'h0000, 16'hFFFF, 1'b0, 0});
    vecs.push_back('{4'hF, 16'hABCD, 16'h1234, 16'h0000, 1'b0, 0});

    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_ovf_sticky", 32'(ovf_sticky), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Add overflow sets the sticky flag on consume; clr_ovf alone clears it.
    out_ready = 1'b1;
    run_op('{4'h0, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 0});
    @(posedge clk); #1;
    check("sticky_after_add_ovf", 32'(ovf_sticky), 32'd1);
    clr_ovf = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    check("sticky_cleared", 32'(ovf_sticky), 32'd0);

    foreach (vecs[i]) run_op(vecs[i]);

    // Backpressure, then consume and accept on the same edge.
    @(posedge clk); #1;
    out_ready = 1'b0;
    clr_ovf   = 1'b1;
    @(posedge clk); #1;
    clr_ovf   = 1'b0;
    in_valid  = 1'b1;
    func_code = 4'h4;
    a         = 16'hF0F0;
    b         = 16'hFF00;
    @(negedge clk);
    check("bp_accept_ready", 32'(in_ready), 32'd1);
    sb.push_back('{16'hF000, 1'b0});
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = 16'h5A5A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_result", 32'(result), 32'hF000);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    func_code = 4'h0;
    a         = 16'h7FFF;
    b         = 16'h0001;
    sb.push_back('{16'h8000, 1'b1});
    @(negedge clk);
    check("b2b_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("b2b_out_valid", 32'(out_valid), 32'd1);
    check("b2b_result", 32'(result), 32'h8000);
    check("b2b_sticky_before", 32'(ovf_sticky), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    clr_ovf   = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    check("sticky_set_wins", 32'(ovf_sticky), 32'd1);
    check("b2b_idle_after", 32'(out_valid), 32'd0);

    // Reset in the second SHIFT cycle drops the pending result.
    @(posedge clk); #1;
    in_valid  = 1'b1;
    func_code = 4'hA;
    a         = 16'h0001;
    b         = 16'h000F;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    check("mid_rst_sticky", 32'(ovf_sticky), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("post_mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("post_mid_rst_in_ready", 32'(in_ready), 32'd1);
    end

    run_op('{4'h8, 16'h1111, 16'h2222, 16'h3333, 1'b0, 0});
    @(posedge clk); #1;
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
